// File: rtl/processor_pkg.sv
// Shared instruction-fetch types: instruction word, fetch address, prefetch entry, FSM state.
// Latency: n/a (types only).
// Backpressure: n/a.
package processor_pkg;

  // Default widths; the prefetch queue's DATA_W/ADDR_W must not exceed these.
  localparam int INSTR_W = 32;
  localparam int IADDR_W = 16;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [IADDR_W-1:0] iaddr_t;

  // One queued instruction together with the PC it was fetched from.
  typedef struct packed {
    instr_t instr;
    iaddr_t pc;
  } pfq_entry_t;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } pfq_state_e;

endpackage

// File: rtl/instr_prefetch_queue_store.sv
// Prefetch entry storage: DEPTH x pfq_entry_t registers, one write port, async read port.
// Latency: write visible on the read port the cycle after WrEn.
// Backpressure: none; the owner guarantees it never writes a live entry.
module pfq_store
  import processor_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             WrEn,
  input  logic [PTR_W-1:0] WrPtr,
  input  pfq_entry_t       WrData,
  input  logic [PTR_W-1:0] RdPtr,
  output pfq_entry_t       RdData
);

  pfq_entry_t mem [DEPTH];

  // Entry registers: cleared on reset, written at WrPtr when enabled.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (WrEn) begin
      mem[WrPtr] <= WrData;
    end
  end

  assign RdData = mem[RdPtr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction-fetch front end with a DEPTH-entry prefetch FIFO; flushes/redirects on E2 branch.
// Latency: FetchEn 1 cycle after reset release, Valid 2 cycles later (1 with PREFETCH_BYPASS_EN).
// Backpressure: issue is credit-limited (Count + RespPend < DEPTH); nStall=0 holds the head.
module instr_prefetch_queue
  import processor_pkg::*;
#(
  parameter int               DATA_W   = INSTR_W,
  parameter int               ADDR_W   = IADDR_W,
  parameter int               DEPTH    = 4,
  parameter int               PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int              PTR_W    = $clog2(DEPTH),
  localparam int              CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              nReset,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic              FetchEn,
  input  logic [DATA_W-1:0] InstrMem,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchAddr,
  input  logic              nStall,
  output logic              Valid,
  output logic [DATA_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] InstrAddrOut,
  output logic [CNT_W-1:0]  Count
);

  pfq_state_e       state, stateNext;
  logic [ADDR_W-1:0] pc, pcQ;
  logic             respPend;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   inFlight;
  logic             issue, push, bypass, fifoValid, outValid, pop, fifoPop, write;
  pfq_entry_t       respEntry, rdData, outEntry, holdEntry;

  // Credit uses registered occupancy only, so a same-cycle pop never opens a slot early.
  assign inFlight  = {1'b0, count} + (CNT_W + 1)'(respPend);
  assign push      = respPend & ~BranchTaken;
  assign respEntry = '{instr: instr_t'(InstrMem), pc: iaddr_t'(pcQ)};
  assign fifoValid = (count != '0);

`ifdef PREFETCH_BYPASS_EN
  // An empty queue forwards the arriving response straight to decode.
  assign bypass = push & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign outValid = fifoValid | bypass;
  assign outEntry = bypass ? respEntry : (fifoValid ? rdData : holdEntry);
  assign pop      = outValid & nStall;
  assign fifoPop  = pop & fifoValid;
  // A bypassed response that decode takes immediately never occupies a slot.
  assign write    = push & ~(bypass & pop);

  // Next-state and issue decision: FLUSH suppresses fetch for one cycle after reset.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      FLUSH:   stateNext = RUN;
      RUN:     issue = ~BranchTaken & (inFlight < (CNT_W + 1)'(DEPTH));
      default: stateNext = FLUSH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= FLUSH;
    else         state <= stateNext;
  end

  // Fetch PC, issued-PC capture and response-pending flag; a branch redirects and drops in-flight.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc       <= RESET_PC;
      pcQ      <= '0;
      respPend <= 1'b0;
    end else begin
      respPend <= issue;
      if (issue) pcQ <= pc;
      if (BranchTaken) pc <= BranchAddr;
      else if (issue)  pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  // FIFO pointers and occupancy; a branch flushes everything (a same-cycle pop is simply absorbed).
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (BranchTaken) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (write)   wrPtr <= wrPtr + PTR_W'(1);
      if (fifoPop) rdPtr <= rdPtr + PTR_W'(1);
      case ({write, fifoPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the last presented entry so the outputs hold steady while the queue is empty.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)       holdEntry <= '0;
    else if (outValid) holdEntry <= outEntry;
  end

  pfq_store #(.DEPTH(DEPTH)) uStore (
    .Clock  (Clock),
    .nReset (nReset),
    .WrEn   (write),
    .WrPtr  (wrPtr),
    .WrData (respEntry),
    .RdPtr  (rdPtr),
    .RdData (rdData)
  );

  assign InstrAddr    = pc;
  assign FetchEn      = issue;
  assign Valid        = outValid;
  assign InstrOut     = DATA_W'(outEntry.instr);
  assign InstrAddrOut = ADDR_W'(outEntry.pc);
  assign Count        = count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: fill, drain, wrap, branch flush, PC wrap, mid-run reset.
// Latency: expectations follow registered Valid, one cycle earlier with PREFETCH_BYPASS_EN.
// Backpressure: nStall driven directly per step.
module tb_instr_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        Clock;
  logic        nReset;
  logic [15:0] InstrAddr, InstrAddr2;
  logic        FetchEn, FetchEn2;
  logic [31:0] InstrMem, InstrMem2;
  logic        BranchTaken, BranchTaken2;
  logic [15:0] BranchAddr, BranchAddr2;
  logic        nStall, nStall2;
  logic        Valid, Valid2;
  logic [31:0] InstrOut, InstrOut2;
  logic [15:0] InstrAddrOut, InstrAddrOut2;
  logic [2:0]  Count, Count2;

  int checks = 0;
  int errors = 0;
  logic [15:0] a2;

  instr_prefetch_queue #(.DATA_W(32), .ADDR_W(16), .DEPTH(4), .PC_STEP(4), .RESET_PC(16'h0000)) dut (
    .Clock(Clock), .nReset(nReset), .InstrAddr(InstrAddr), .FetchEn(FetchEn), .InstrMem(InstrMem),
    .BranchTaken(BranchTaken), .BranchAddr(BranchAddr), .nStall(nStall), .Valid(Valid),
    .InstrOut(InstrOut), .InstrAddrOut(InstrAddrOut), .Count(Count)
  );

  instr_prefetch_queue #(.DATA_W(32), .ADDR_W(16), .DEPTH(4), .PC_STEP(4), .RESET_PC(16'hFFF8)) dut2 (
    .Clock(Clock), .nReset(nReset), .InstrAddr(InstrAddr2), .FetchEn(FetchEn2), .InstrMem(InstrMem2),
    .BranchTaken(BranchTaken2), .BranchAddr(BranchAddr2), .nStall(nStall2), .Valid(Valid2),
    .InstrOut(InstrOut2), .InstrAddrOut(InstrAddrOut2), .Count(Count2)
  );

  // Instruction image: upper half is the inverted address, lower half the address.
  function automatic logic [31:0] mk(input logic [15:0] a);
    return {~a, a};
  endfunction

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // One-cycle-latency instruction memory for each instance.
  always @(posedge Clock) begin
    InstrMem  <= FetchEn  ? mk(InstrAddr)  : 32'hDEADBEEF;
    InstrMem2 <= FetchEn2 ? mk(InstrAddr2) : 32'hDEADBEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; BranchTaken = 1'b0; BranchAddr = '0; nStall = 1'b0;
    BranchTaken2 = 1'b0; BranchAddr2 = '0; nStall2 = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_valid", Valid, 0);
    chk("rst_count", Count, 0);
    chk("rst_instr", InstrOut, 0);
    chk("rst_iaddr", InstrAddrOut, 0);
    chk("rst_fetchen", FetchEn, 0);
    chk("rst_pc", InstrAddr, 16'h0000);
    chk("rst_pc2", InstrAddr2, 16'hFFF8);
    chk("rst_count2", Count2, 0);

    // Fill with decode stalled; second instance runs freely from 0xFFF8.
    @(negedge Clock);
    nReset = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge Clock);
        #1;
      end
      chk("t1_fetchen", FetchEn, (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk("t1_addr", InstrAddr, 4 * (k - 1));
      chk("t1_valid", Valid, (k >= 3 - BYP));
      chk("t1_count", Count, (k < 3) ? 0 : ((k - 2 > 4) ? 4 : k - 2));
      chk("t5_fetchen", FetchEn2, (k >= 1));
      if (k >= 1 && k <= 4) begin
        a2 = 16'hFFF8 + 16'(4 * (k - 1));
        chk("t5_addr", InstrAddr2, a2);
      end
      chk("t5_valid", Valid2, (k >= 3 - BYP));
      if (k >= 3 - BYP) begin
        a2 = 16'hFFF8 + 16'(4 * (k - (3 - BYP)));
        chk("t5_pcout", InstrAddrOut2, a2);
        chk("t5_instr", InstrOut2, mk(a2));
      end
    end
    chk("t1_head_pc", InstrAddrOut, 16'h0000);
    chk("t1_head_instr", InstrOut, mk(16'h0000));

    // Drain from full: 0x00..0x1C one per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      nStall = 1'b1;
      #1;
      chk("t2_valid", Valid, 1);
      chk("t2_pc", InstrAddrOut, 4 * i);
      chk("t2_instr", InstrOut, mk(16'(4 * i)));
      chk("t2_count", Count, (i == 0) ? 4 : ((i == 1) ? 3 : 2));
    end

    // Steady push+pop at Count=2 across several pointer wraps.
    for (int j = 0; j < 12; j++) begin
      @(negedge Clock);
      #1;
      chk("t4_pc", InstrAddrOut, 16'h0020 + 16'(4 * j));
      chk("t4_count", Count, 2);
    end

    // Branch with Count=3 and 0x5C in flight.
    @(negedge Clock);
    nStall = 1'b0;
    #1;
    chk("t3_pre_count", Count, 2);
    @(negedge Clock);
    #1;
    chk("t3_br_count", Count, 3);
    chk("t3_br_head", InstrAddrOut, 16'h0050);
    BranchTaken = 1'b1;
    BranchAddr  = 16'h0100;
    #1;
    chk("t3_br_fetchen", FetchEn, 0);
    @(negedge Clock);
    BranchTaken = 1'b0;
    #1;
    chk("t3_post_count", Count, 0);
    chk("t3_post_valid", Valid, 0);
    chk("t3_post_addr", InstrAddr, 16'h0100);
    chk("t3_post_fetchen", FetchEn, 1);
    chk("t3_hold_pc", InstrAddrOut, 16'h0050);
    @(negedge Clock);
    #1;
    chk("t3_early_valid", Valid, BYP);
    if (BYP == 1) chk("t3_bypass_pc", InstrAddrOut, 16'h0100);
    chk("t3_next_addr", InstrAddr, 16'h0104);
    @(negedge Clock);
    nStall = 1'b1;
    #1;
    chk("t3_valid", Valid, 1);
    chk("t3_target_pc", InstrAddrOut, 16'h0100);
    chk("t3_target_instr", InstrOut, mk(16'h0100));
    @(negedge Clock);
    #1;
    chk("t3_seq1", InstrAddrOut, 16'h0104);
    @(negedge Clock);
    #1;
    chk("t3_seq2", InstrAddrOut, 16'h0108);
    chk("t3_seq2_count", Count, 1);

    // Build Count=2, then pulse reset mid-cycle.
    @(negedge Clock);
    nStall = 1'b0;
    #1;
    chk("t6_pre_pc", InstrAddrOut, 16'h010C);
    @(negedge Clock);
    #1;
    chk("t6_pre_count", Count, 2);
    #2;
    nReset = 1'b0;
    #1;
    chk("t6_async_valid", Valid, 0);
    chk("t6_async_count", Count, 0);
    chk("t6_async_instr", InstrOut, 0);
    chk("t6_async_iaddr", InstrAddrOut, 0);
    chk("t6_async_fetchen", FetchEn, 0);
    chk("t6_async_pc", InstrAddr, 16'h0000);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge Clock);
        #1;
      end
      chk("t6_valid", Valid, (k >= 3 - BYP));
      if (k >= 3 - BYP) chk("t6_first_pc", InstrAddrOut, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
